// File: rtl/cfu_cmd_initiator.sv
// Command initiator for the conv1d CFU: FIFOs host requests and drives one command at a time
// over cmd/rsp with a WAIT timeout. Define CFU_INIT_RETRY_EN to re-issue timed-out commands.
module cfu_cmd_initiator #(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT     = 15,
  parameter int MAX_RETRIES = 7
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [6:0]  req_funct7,
  input  logic [31:0] req_inp0,
  input  logic [31:0] req_inp1,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_error,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [9:0]  cmd_payload_function_id,
  output logic [31:0] cmd_payload_inputs_0,
  output logic [31:0] cmd_payload_inputs_1,
  input  logic        rsp_valid,
  output logic        rsp_ready,
  input  logic [31:0] rsp_payload_outputs_0,
  output logic        busy,
  output logic [7:0]  error_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = 7 + 32 + 32;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DELIVER} state_t;

  generate
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        TIMEOUT < 1 || TIMEOUT > 255 || MAX_RETRIES < 0 || MAX_RETRIES > 15) begin : g_param_check
      $error("cfu_cmd_initiator: parameter out of range");
    end
  endgenerate

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t        state, state_nxt;
  logic [EW-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          fifo_empty, fifo_full, push, pop;
  logic          nempty_p0;
  logic [EW-1:0] head;
  logic [7:0]    tmo_cnt;
  logic          tmo_hit, tmo_clr, retry_ok;
  logic          take_rsp, take_err;

  // Request FIFO; pointer MSB distinguishes full from empty after wrap
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push       = req_valid && !fifo_full;
  assign head       = fifo_mem[rd_ptr[AW-1:0]];
  assign req_ready  = !fifo_full;
  assign busy       = !fifo_empty || (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= {req_funct7, req_inp0, req_inp1};
  end

  // Stage p0: registered non-empty flag gates the IDLE -> ISSUE decision
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      nempty_p0 <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      nempty_p0 <= !fifo_empty;
    end
  end

  assign tmo_hit = (tmo_cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              tmo_cnt <= '0;
    else if (tmo_clr)          tmo_cnt <= '0;
    else if (state == ST_WAIT) tmo_cnt <= tmo_cnt + 8'd1;
  end

`ifdef CFU_INIT_RETRY_EN
  logic [3:0] retry_cnt;

  assign retry_ok = (retry_cnt < 4'(MAX_RETRIES));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      retry_cnt <= '0;
    end else if (state == ST_WAIT) begin
      if (rsp_valid || (tmo_hit && !retry_ok)) retry_cnt <= '0;
      else if (tmo_hit)                         retry_cnt <= retry_cnt + 4'd1;
    end
  end
`else
  assign retry_ok = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt               = state;
    pop                     = 1'b0;
    tmo_clr                 = 1'b0;
    take_rsp                = 1'b0;
    take_err                = 1'b0;
    cmd_valid               = 1'b0;
    rsp_ready               = 1'b0;
    resp_valid              = 1'b0;
    cmd_payload_function_id = '0;
    cmd_payload_inputs_0    = '0;
    cmd_payload_inputs_1    = '0;
    unique case (state)
      ST_IDLE: begin
        if (nempty_p0) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        cmd_valid               = 1'b1;
        cmd_payload_function_id = {head[70:64], 3'b000};
        cmd_payload_inputs_0    = head[63:32];
        cmd_payload_inputs_1    = head[31:0];
        if (cmd_ready) begin
          tmo_clr   = 1'b1;
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        rsp_ready = 1'b1;
        // A response arriving in the timeout cycle still wins
        if (rsp_valid) begin
          take_rsp  = 1'b1;
          pop       = 1'b1;
          state_nxt = ST_DELIVER;
        end else if (tmo_hit) begin
          if (retry_ok) begin
            state_nxt = ST_ISSUE;
          end else begin
            take_err  = 1'b1;
            pop       = 1'b1;
            state_nxt = ST_DELIVER;
          end
        end
      end
      ST_DELIVER: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_data   <= '0;
      resp_error  <= 1'b0;
      error_count <= '0;
    end else if (take_rsp) begin
      resp_data  <= rsp_payload_outputs_0;
      resp_error <= 1'b0;
    end else if (take_err) begin
      resp_data   <= '0;
      resp_error  <= 1'b1;
      error_count <= sat_inc8(error_count);
    end
  end

endmodule

// File: tb/tb_cfu_cmd_initiator.sv
// Directed bench for cfu_cmd_initiator with a small scripted CFU responder.
module tb_cfu_cmd_initiator;
  localparam int DEPTH = 4;
  localparam int TMO = 15;
  localparam int RETRIES = 7;
`ifdef CFU_INIT_RETRY_EN
  localparam int RETRY = 1;
`else
  localparam int RETRY = 0;
`endif
  localparam int NISSUE = (RETRY != 0) ? RETRIES + 1 : 1;

  logic        clk, reset_n;
  logic        req_valid, req_ready;
  logic [6:0]  req_funct7;
  logic [31:0] req_inp0, req_inp1;
  logic        resp_valid, resp_ready, resp_error;
  logic [31:0] resp_data;
  logic        cmd_valid, cmd_ready;
  logic [9:0]  cmd_payload_function_id;
  logic [31:0] cmd_payload_inputs_0, cmd_payload_inputs_1;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_payload_outputs_0;
  logic        busy;
  logic [7:0]  error_count;

  int          n_chk, n_bad;
  int          hs_count, skip_until, cfu_delay;
  logic [31:0] cfu_value;
  bit          echo;

  cfu_cmd_initiator #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO), .MAX_RETRIES(RETRIES)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct7(req_funct7),
    .req_inp0(req_inp0), .req_inp1(req_inp1),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_error(resp_error),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_payload_function_id(cmd_payload_function_id),
    .cmd_payload_inputs_0(cmd_payload_inputs_0), .cmd_payload_inputs_1(cmd_payload_inputs_1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_payload_outputs_0(rsp_payload_outputs_0),
    .busy(busy), .error_count(error_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // CFU model: always ready; answers commands after hs_count passes skip_until,
  // raising rsp_valid in WAIT cycle cfu_delay-1
  initial begin
    int          pend;
    logic [31:0] cap0, cap1;
    pend = 0; cap0 = '0; cap1 = '0; hs_count = 0;
    cmd_ready = 1'b1; rsp_valid = 1'b0; rsp_payload_outputs_0 = '0;
    forever begin
      @(negedge clk);
      rsp_valid = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          rsp_valid = 1'b1;
          rsp_payload_outputs_0 = echo ? cap0 + cap1 : cfu_value;
        end
      end
      if (cmd_valid && cmd_ready) begin
        hs_count++;
        cap0 = cmd_payload_inputs_0;
        cap1 = cmd_payload_inputs_1;
        if (hs_count > skip_until) pend = cfu_delay;
      end
    end
  end

  task automatic push(input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    req_valid = 1'b1; req_funct7 = f7; req_inp0 = a; req_inp1 = b;
    while (!req_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("push_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_cmd(output int n);
    n = 0;
    while (!cmd_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_seen", 32'(cmd_valid), 32'd1);
  endtask

  task automatic get_resp(output logic [31:0] d, output logic e, output int n);
    n = 0;
    while (!resp_valid && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("resp_seen", 32'(resp_valid), 32'd1);
    d = resp_data;
    e = resp_error;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic        e;
    int          n, hs0;
    n_chk = 0; n_bad = 0;
    reset_n = 1'b1; req_valid = 1'b0; req_funct7 = '0; req_inp0 = '0; req_inp1 = '0;
    resp_ready = 1'b0; skip_until = 0; cfu_delay = 1; cfu_value = '0; echo = 1'b0;
    #2 reset_n = 1'b0;
    #2;
    chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("rst_rsp_ready", 32'(rsp_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_error", 32'(resp_error), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_fid", 32'(cmd_payload_function_id), 32'd0);
    chk("rst_in0", cmd_payload_inputs_0, 32'd0);
    chk("rst_in1", cmd_payload_inputs_1, 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_errcnt", 32'(error_count), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Basic command, response in first WAIT cycle
    echo = 1'b0; cfu_value = 32'h0; cfu_delay = 1; skip_until = hs_count;
    push(7'd4, 32'd8, 32'd0);
    chk("t1_lat0", 32'(cmd_valid), 32'd0);
    @(negedge clk);
    chk("t1_lat1", 32'(cmd_valid), 32'd0);
    @(negedge clk);
    chk("t1_lat2", 32'(cmd_valid), 32'd1);
    chk("t1_fid", 32'(cmd_payload_function_id), 32'h020);
    chk("t1_in0", cmd_payload_inputs_0, 32'd8);
    get_resp(d, e, n);
    chk("t1_cyc", 32'(n), 32'd2);
    chk("t1_data", d, 32'h0);
    chk("t1_err", 32'(e), 32'd0);
    chk("t1_errcnt", 32'(error_count), 32'd0);

    // Response after three WAIT cycles
    cfu_value = 32'h11131517; cfu_delay = 3; skip_until = hs_count;
    push(7'd3, 32'd0, 32'd0);
    wait_cmd(n);
    chk("t2_lat", 32'(n), 32'd2);
    chk("t2_fid", 32'(cmd_payload_function_id), 32'h018);
    get_resp(d, e, n);
    chk("t2_cyc", 32'(n), 32'd4);
    chk("t2_data", d, 32'h11131517);
    chk("t2_err", 32'(e), 32'd0);

    // Response in the same cycle the timeout would fire
    cfu_value = 32'h5A5A; cfu_delay = TMO; skip_until = hs_count; hs0 = hs_count;
    push(7'd5, 32'd1, 32'd2);
    wait_cmd(n);
    get_resp(d, e, n);
    chk("t2b_cyc", 32'(n), 32'(TMO + 1));
    chk("t2b_data", d, 32'h5A5A);
    chk("t2b_err", 32'(e), 32'd0);
    chk("t2b_hs", 32'(hs_count - hs0), 32'd1);

    // First issue dropped, second answered
    cfu_value = 32'hA5; cfu_delay = 1; hs0 = hs_count; skip_until = hs_count + 1;
    push(7'd1, 32'd5, 32'd6);
    wait_cmd(n);
    get_resp(d, e, n);
    chk("t3_cyc", 32'(n), 32'((RETRY != 0) ? TMO + 3 : TMO + 1));
    chk("t3_hs", 32'(hs_count - hs0), 32'((RETRY != 0) ? 2 : 1));
    chk("t3_data", d, (RETRY != 0) ? 32'hA5 : 32'h0);
    chk("t3_err", 32'(e), 32'((RETRY != 0) ? 0 : 1));
    chk("t3_errcnt", 32'(error_count), 32'((RETRY != 0) ? 0 : 1));

    // CFU never answers
    hs0 = hs_count; skip_until = hs_count + 1000;
    push(7'd9, 32'd1, 32'd1);
    wait_cmd(n);
    get_resp(d, e, n);
    chk("t4_cyc", 32'(n), 32'(NISSUE * (TMO + 1)));
    chk("t4_hs", 32'(hs_count - hs0), 32'(NISSUE));
    chk("t4_data", d, 32'h0);
    chk("t4_err", 32'(e), 32'd1);
    chk("t4_errcnt", 32'(error_count), 32'((RETRY != 0) ? 1 : 2));

    // Host stall: FIFO fills behind a held result, then drains in order
    echo = 1'b1; cfu_delay = 1; skip_until = hs_count; resp_ready = 1'b0;
    for (int k = 1; k <= DEPTH; k++) push(7'(k), 32'(16 * k), 32'(k));
    chk("t5_full", 32'(req_ready), 32'd0);
    push(7'd5, 32'd80, 32'd5);
    repeat (3) @(negedge clk);
    chk("t5_stall_rdy", 32'(req_ready), 32'd0);
    chk("t5_stall_vld", 32'(resp_valid), 32'd1);
    chk("t5_stall_busy", 32'(busy), 32'd1);
    chk("t5_stall_data", resp_data, 32'd17);
    for (int k = 1; k <= DEPTH + 1; k++) begin
      get_resp(d, e, n);
      chk("t5_data", d, 32'(17 * k));
      chk("t5_err", 32'(e), 32'd0);
    end

    // Asynchronous reset in the middle of WAIT
    echo = 1'b0; skip_until = hs_count + 1000;
    push(7'd6, 32'd3, 32'd4);
    wait_cmd(n);
    @(negedge clk);
    chk("t6_in_wait", 32'(rsp_ready), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("t6_resp_valid", 32'(resp_valid), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_rsp_ready", 32'(rsp_ready), 32'd0);
    chk("t6_req_ready", 32'(req_ready), 32'd1);
    chk("t6_errcnt", 32'(error_count), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    echo = 1'b1; cfu_delay = 1; skip_until = hs_count;
    push(7'd2, 32'd7, 32'd9);
    wait_cmd(n);
    chk("t6_fid", 32'(cmd_payload_function_id), 32'h010);
    get_resp(d, e, n);
    chk("t6_data", d, 32'd16);
    chk("t6_err", 32'(e), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
